// File: rtl/sprite_compositor.sv
// N-sprite pixel compositor: tests the scan position against N rectangles, resolves
// overlaps by fixed priority (index 0 wins) and emits a registered pixel two cycles later.

`ifndef X_POS_W
`define X_POS_W 10
`endif
`ifndef Y_POS_W
`define Y_POS_W 10
`endif
`ifndef VGA_RGB_W
`define VGA_RGB_W 12
`endif

module sprite_compositor #(
  parameter int N_SPRITES    = 4,
  parameter int X_W          = `X_POS_W,
  parameter int Y_W          = `Y_POS_W,
  parameter int RGB_W        = `VGA_RGB_W,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [X_W-1:0]                   x_pos_i,
  input  logic [Y_W-1:0]                   y_pos_i,
  input  logic                             visible_i,
  input  logic                             frame_start_i,
  input  logic [N_SPRITES*X_W-1:0]         spr_x_i,
  input  logic [N_SPRITES*Y_W-1:0]         spr_y_i,
  input  logic [N_SPRITES*X_W-1:0]         spr_w_i,
  input  logic [N_SPRITES*Y_W-1:0]         spr_h_i,
  input  logic [N_SPRITES-1:0]             spr_en_i,
  input  logic [N_SPRITES-1:0]             spr_blink_i,
  input  logic                             cfg_we_i,
  input  logic [$clog2(N_SPRITES+1)-1:0]   cfg_idx_i,
  input  logic [RGB_W-1:0]                 cfg_rgb_i,
  output logic [RGB_W-1:0]                 rgb_o,
  output logic                             visible_o,
  output logic [N_SPRITES-1:0]             coll_o
);

  localparam int N  = N_SPRITES;
  localparam int IW = $clog2(N + 1);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [N-1:0]     hit;
  logic [N-1:0]     hit1_q, hit1_d;
  logic             vis1_q, vis1_d;
  logic             fs1_q, fs1_d;
  logic [N-1:0]     acc_q, acc_d;
  logic [N-1:0]     coll_q, coll_d;
  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic             vis2_q, vis2_d;
  logic [RGB_W-1:0] colour_q [N];
  logic [RGB_W-1:0] colour_d [N];
  logic [RGB_W-1:0] bg_q, bg_d;
  logic [BW-1:0]    blink_cnt_q, blink_cnt_d;
  logic             phase_q, phase_d;
  logic [4:0]       n_hit;
  logic [N-1:0]     coll_term;
  logic [RGB_W-1:0] pix;

  // Right/bottom edges are formed one bit wider so sprites near the edge clip instead of wrapping.
  always_comb begin
    hit = '0;
    for (int i = 0; i < N; i++) begin
      hit[i] = spr_en_i[i] & ~(spr_blink_i[i] & phase_q)
             & (x_pos_i >= spr_x_i[i*X_W +: X_W])
             & ({1'b0, x_pos_i} < ({1'b0, spr_x_i[i*X_W +: X_W]} + {1'b0, spr_w_i[i*X_W +: X_W]}))
             & (y_pos_i >= spr_y_i[i*Y_W +: Y_W])
             & ({1'b0, y_pos_i} < ({1'b0, spr_y_i[i*Y_W +: Y_W]} + {1'b0, spr_h_i[i*Y_W +: Y_W]}));
    end
  end

  always_comb begin
    hit1_d = hit;
    vis1_d = visible_i;
    fs1_d  = frame_start_i;

    n_hit = '0;
    for (int i = 0; i < N; i++) begin
      n_hit = n_hit + 5'(hit1_q[i]);
    end
    coll_term = hit1_q & {N{vis1_q && (n_hit >= 5'd2)}};

    // The frame-start pixel belongs to the new frame, so it seeds the fresh accumulator.
    if (fs1_q) begin
      coll_d = acc_q;
      acc_d  = coll_term;
    end else begin
      coll_d = coll_q;
      acc_d  = acc_q | coll_term;
    end

    pix = bg_q;
    for (int i = N - 1; i >= 0; i--) begin
      if (hit1_q[i]) pix = colour_q[i];
    end
    rgb_d  = vis1_q ? pix : '0;
    vis2_d = vis1_q;

    colour_d = colour_q;
    bg_d     = bg_q;
    if (cfg_we_i) begin
      for (int i = 0; i < N; i++) begin
        if (cfg_idx_i == IW'(i)) colour_d[i] = cfg_rgb_i;
      end
      if (cfg_idx_i == IW'(N)) bg_d = cfg_rgb_i;
    end

    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (frame_start_i) begin
      if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit1_q      <= '0;
      vis1_q      <= 1'b0;
      fs1_q       <= 1'b0;
      acc_q       <= '0;
      coll_q      <= '0;
      rgb_q       <= '0;
      vis2_q      <= 1'b0;
      colour_q    <= '{default: '0};
      bg_q        <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      hit1_q      <= hit1_d;
      vis1_q      <= vis1_d;
      fs1_q       <= fs1_d;
      acc_q       <= acc_d;
      coll_q      <= coll_d;
      rgb_q       <= rgb_d;
      vis2_q      <= vis2_d;
      colour_q    <= colour_d;
      bg_q        <= bg_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign rgb_o     = rgb_q;
  assign visible_o = vis2_q;
  assign coll_o    = coll_q;

endmodule
